// File: rtl/fpu_ss_pkg.sv
// rtl/fpu_ss_pkg.sv - FPU subsystem shared types for the load/store sequencer
//
// Purpose: access-size and LSU state enums, plus the alignment check used at accept.
// Contents:
//   ls_size_e     - Byte/HalfWord/Word/DoubleWord access size
//   lsu_state_e   - load/store sequencer FSM states
//   ls_misaligned - 1 when the byte address is not naturally aligned for the size
package fpu_ss_pkg;

  typedef enum logic [1:0] {
    LS_BYTE   = 2'd0,
    LS_HALF   = 2'd1,
    LS_WORD   = 2'd2,
    LS_DOUBLE = 2'd3
  } ls_size_e;

  typedef enum logic [2:0] {
    LSU_IDLE  = 3'd0,
    LSU_REQ0  = 3'd1,
    LSU_RESP0 = 3'd2,
    LSU_REQ1  = 3'd3,
    LSU_RESP1 = 3'd4,
    LSU_WB    = 3'd5
  } lsu_state_e;

  function automatic logic ls_misaligned(input ls_size_e size, input logic [2:0] addr_lo);
    logic mis;
    mis = 1'b0;
    case (size)
      LS_BYTE:   mis = 1'b0;
      LS_HALF:   mis = addr_lo[0];
      LS_WORD:   mis = |addr_lo[1:0];
      default:   mis = |addr_lo;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/fpu_ss_lsu_ctrl_if.sv
// rtl/fpu_ss_lsu_ctrl_if.sv - 32-bit memory request/result bus of the FPU load/store sequencer
//
// Purpose: bundles the memory request handshake and the result channel.
// Signals:
//   valid/ready                  request handshake (master drives valid)
//   addr/we/be/wdata/id          word-aligned beat request fields
//   result_valid/rdata/err       single-cycle response from memory
// Modports: master = sequencer side, slave = memory side.
interface fpu_ss_lsu_ctrl_if #(
  parameter int X_ID_WIDTH = 4
) ();

  logic                  valid;
  logic                  ready;
  logic [31:0]           addr;
  logic                  we;
  logic [3:0]            be;
  logic [31:0]           wdata;
  logic [X_ID_WIDTH-1:0] id;
  logic                  result_valid;
  logic [31:0]           result_rdata;
  logic                  result_err;

  modport master (
    output valid, addr, we, be, wdata, id,
    input  ready, result_valid, result_rdata, result_err
  );

  modport slave (
    input  valid, addr, we, be, wdata, id,
    output ready, result_valid, result_rdata, result_err
  );

endinterface

// File: rtl/fpu_ss_lsu_align.sv
// rtl/fpu_ss_lsu_align.sv - byte-enable / lane replication / load extraction and NaN-boxing
//
// Purpose: purely combinational data path for the load/store sequencer.
// Ports:
//   size_i      access size
//   addr_lo_i   byte address bits [1:0]
//   beat_i      0 = first word beat, 1 = second (DoubleWord only)
//   wdata_i     FLEN-bit store data, LSBs significant
//   rdata0_i    word returned by beat 0
//   rdata1_i    word returned by beat 1
//   be_o        byte enables for the current beat
//   wdata_o     lane-replicated write data for the current beat
//   ldata_o     NaN-boxed load result
module fpu_ss_lsu_align
  import fpu_ss_pkg::*;
#(
  parameter int FLEN = 64
) (
  input  ls_size_e          size_i,
  input  logic [1:0]        addr_lo_i,
  input  logic              beat_i,
  input  logic [FLEN-1:0]   wdata_i,
  input  logic [31:0]       rdata0_i,
  input  logic [31:0]       rdata1_i,
  output logic [3:0]        be_o,
  output logic [31:0]       wdata_o,
  output logic [FLEN-1:0]   ldata_o
);

  logic [63:0] wd64;
  logic [63:0] ld64;
  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  always_comb begin
    // Widen store data so the second-beat slice exists for any FLEN.
    wd64            = '0;
    wd64[FLEN-1:0]  = wdata_i;

    lane_b = rdata0_i[{addr_lo_i, 3'b000} +: 8];
    lane_h = rdata0_i[{addr_lo_i[1], 4'b0000} +: 16];

    be_o    = 4'hF;
    wdata_o = wd64[31:0];
    ld64    = {32'hFFFF_FFFF, rdata0_i};

    case (size_i)
      LS_BYTE: begin
        be_o    = 4'b0001 << addr_lo_i;
        wdata_o = {4{wd64[7:0]}};
        ld64    = {56'hFF_FFFF_FFFF_FFFF, lane_b};
      end
      LS_HALF: begin
        be_o    = 4'b0011 << addr_lo_i;
        wdata_o = {2{wd64[15:0]}};
        ld64    = {48'hFFFF_FFFF_FFFF, lane_h};
      end
      LS_WORD: begin
        be_o    = 4'hF;
        wdata_o = wd64[31:0];
        ld64    = {32'hFFFF_FFFF, rdata0_i};
      end
      default: begin
        be_o    = 4'hF;
        wdata_o = beat_i ? wd64[63:32] : wd64[31:0];
        ld64    = {rdata1_i, rdata0_i};
      end
    endcase

    ldata_o = ld64[FLEN-1:0];
  end

endmodule

// File: rtl/fpu_ss_lsu_ctrl.sv
// rtl/fpu_ss_lsu_ctrl.sv - FPU load/store sequencer driving a 32-bit memory bus
//
// Purpose: accepts one decoded FP load/store, checks legality, issues one or two
// word beats, and returns a single writeback/completion record.
// Ports:
//   clk_i, rst_i                     clock, synchronous active-high reset
//   ls_valid_i/ls_ready_o            request handshake from decoder
//   ls_we_i/size_i/addr_i/wdata_i    request fields
//   ls_rd_i/ls_id_i                  destination register and instruction ID
//   x_mem                            memory request/result bus (master)
//   wb_valid_o/wb_ready_i            completion handshake
//   wb_rf_we_o/rd_o/data_o/id_o/err_o completion fields
module fpu_ss_lsu_ctrl
  import fpu_ss_pkg::*;
#(
  parameter int FLEN       = 64,
  parameter int X_ID_WIDTH = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,

  input  logic                  ls_valid_i,
  output logic                  ls_ready_o,
  input  logic                  ls_we_i,
  input  ls_size_e              ls_size_i,
  input  logic [31:0]           ls_addr_i,
  input  logic [FLEN-1:0]       ls_wdata_i,
  input  logic [4:0]            ls_rd_i,
  input  logic [X_ID_WIDTH-1:0] ls_id_i,

  fpu_ss_lsu_ctrl_if.master     x_mem,

  output logic                  wb_valid_o,
  input  logic                  wb_ready_i,
  output logic                  wb_rf_we_o,
  output logic [4:0]            wb_rd_o,
  output logic [FLEN-1:0]       wb_data_o,
  output logic [X_ID_WIDTH-1:0] wb_id_o,
  output logic                  wb_err_o
);

  lsu_state_e            state_q,  state_d;
  logic                  we_q,     we_d;
  ls_size_e              size_q,   size_d;
  logic [31:0]           addr_q,   addr_d;
  logic [FLEN-1:0]       wdata_q,  wdata_d;
  logic [4:0]            rd_q,     rd_d;
  logic [X_ID_WIDTH-1:0] id_q,     id_d;
  logic                  err_q,    err_d;
  logic [31:0]           rdata0_q, rdata0_d;
  logic [31:0]           rdata1_q, rdata1_d;

  logic                  illegal;
  logic                  mem_active;
  logic                  beat1;
  logic [3:0]            be;
  logic [31:0]           beat_wdata;
  logic [FLEN-1:0]       ldata;

  // DoubleWord cannot be held in a 32-bit register file.
  assign illegal = (ls_size_i == LS_DOUBLE) && (FLEN < 64);

  always_comb begin
    state_d  = state_q;
    we_d     = we_q;
    size_d   = size_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rd_d     = rd_q;
    id_d     = id_q;
    err_d    = err_q;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;

    case (state_q)
      LSU_IDLE: begin
        if (ls_valid_i) begin
          we_d     = ls_we_i;
          size_d   = ls_size_i;
          addr_d   = ls_addr_i;
          wdata_d  = ls_wdata_i;
          rd_d     = ls_rd_i;
          id_d     = ls_id_i;
          rdata0_d = '0;
          rdata1_d = '0;
          err_d    = illegal || ls_misaligned(ls_size_i, ls_addr_i[2:0]);
          state_d  = err_d ? LSU_WB : LSU_REQ0;
        end
      end
      LSU_REQ0: begin
        if (x_mem.ready) state_d = LSU_RESP0;
      end
      LSU_RESP0: begin
        if (x_mem.result_valid) begin
          rdata0_d = x_mem.result_rdata;
          if (x_mem.result_err) begin
            err_d   = 1'b1;
            state_d = LSU_WB;
          end else if (size_q == LS_DOUBLE) begin
            state_d = LSU_REQ1;
          end else begin
            state_d = LSU_WB;
          end
        end
      end
      LSU_REQ1: begin
        if (x_mem.ready) state_d = LSU_RESP1;
      end
      LSU_RESP1: begin
        if (x_mem.result_valid) begin
          rdata1_d = x_mem.result_rdata;
          err_d    = err_q | x_mem.result_err;
          state_d  = LSU_WB;
        end
      end
      LSU_WB: begin
        if (wb_ready_i) state_d = LSU_IDLE;
      end
      default: state_d = LSU_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= LSU_IDLE;
      we_q     <= 1'b0;
      size_q   <= LS_BYTE;
      addr_q   <= '0;
      wdata_q  <= '0;
      rd_q     <= '0;
      id_q     <= '0;
      err_q    <= 1'b0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      state_q  <= state_d;
      we_q     <= we_d;
      size_q   <= size_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rd_q     <= rd_d;
      id_q     <= id_d;
      err_q    <= err_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
    end
  end

  fpu_ss_lsu_align #(.FLEN(FLEN)) u_align (
    .size_i    (size_q),
    .addr_lo_i (addr_q[1:0]),
    .beat_i    (beat1),
    .wdata_i   (wdata_q),
    .rdata0_i  (rdata0_q),
    .rdata1_i  (rdata1_q),
    .be_o      (be),
    .wdata_o   (beat_wdata),
    .ldata_o   (ldata)
  );

  assign ls_ready_o = (state_q == LSU_IDLE);
  assign mem_active = (state_q == LSU_REQ0) || (state_q == LSU_REQ1);
  assign beat1      = (state_q == LSU_REQ1);

  // Bus fields are zeroed outside a request so nothing stale is visible.
  assign x_mem.valid = mem_active;
  assign x_mem.addr  = mem_active ? ({addr_q[31:2], 2'b00} + (beat1 ? 32'd4 : 32'd0)) : '0;
  assign x_mem.we    = mem_active & we_q;
  assign x_mem.be    = mem_active ? be : 4'h0;
  assign x_mem.wdata = mem_active ? beat_wdata : '0;
  assign x_mem.id    = mem_active ? id_q : '0;

  assign wb_valid_o = (state_q == LSU_WB);
  assign wb_rf_we_o = wb_valid_o & ~we_q & ~err_q;
  assign wb_rd_o    = wb_valid_o ? rd_q : '0;
  assign wb_data_o  = wb_rf_we_o ? ldata : '0;
  assign wb_id_o    = wb_valid_o ? id_q : '0;
  assign wb_err_o   = wb_valid_o & err_q;

endmodule
